// File: rtl/enemy_pkg.sv
// enemy_pkg: shared life-cycle states, default enemy constants and saturating add
package enemy_pkg;
   typedef enum logic [1:0] {DEAD = 2'd0, SPAWN = 2'd1, ALIVE = 2'd2, HURT = 2'd3} enemy_state_e;
   localparam int DEF_NUM_ATK = 2;
   localparam int DEF_COORD_W = 9;
   localparam int DEF_HP_W = 7;
   localparam int DEF_FULL_HP = 100;
   localparam logic [13:0] DEF_ATK_DMG = {7'd25, 7'd10};
   localparam int DEF_ENEMY_W = 26;
   localparam int DEF_ENEMY_H = 26;
   localparam int DEF_SPAWN_FRAMES = 30;
   localparam int DEF_INV_FRAMES = 8;
   localparam int DEF_ENEMY_DMG = 10;
   localparam int DEF_DMG_W = 10;
   localparam int DEF_SCORE_W = 10;
   function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b, input int unsigned w);
      logic [32:0] s, m;
      s = {1'b0, a} + {1'b0, b};
      m = (33'd1 << w) - 33'd1;
      return (s > m) ? m[31:0] : s[31:0];
   endfunction
endpackage

// File: rtl/enemy_health_fsm_aabb_hit.sv
// aabb_hit: inclusive overlap test between the enemy hitbox and one attack box
module aabb_hit #(
   parameter int COORD_W = 9,
   parameter int ENEMY_W = 26,
   parameter int ENEMY_H = 26
) (
   input  logic               on,
   input  logic [COORD_W-1:0] ex,
   input  logic [COORD_W-1:0] ey,
   input  logic [COORD_W-1:0] ax,
   input  logic [COORD_W-1:0] ay,
   input  logic [COORD_W-1:0] aw,
   input  logic [COORD_W-1:0] ah,
   output logic               hit
);
   localparam int SW = COORD_W + 1;
   logic [SW-1:0] e_r, e_b, a_r, a_b;
   // one extra bit keeps right/bottom edges from wrapping near the screen limit
   assign e_r = SW'(ex) + SW'(ENEMY_W);
   assign e_b = SW'(ey) + SW'(ENEMY_H);
   assign a_r = SW'(ax) + SW'(aw);
   assign a_b = SW'(ay) + SW'(ah);
   assign hit = on & (e_r >= SW'(ax)) & (SW'(ex) <= a_r) & (e_b >= SW'(ay)) & (SW'(ey) <= a_b);
endmodule

// File: rtl/enemy_health_fsm.sv
// enemy_health_fsm: per-enemy health, respawn, invulnerability and scoring controller
module enemy_health_fsm
   import enemy_pkg::*;
#(
   parameter int ENEMY_ID = 0,
   parameter int NUM_ATK = DEF_NUM_ATK,
   parameter int COORD_W = DEF_COORD_W,
   parameter int HP_W = DEF_HP_W,
   parameter int FULL_HP = DEF_FULL_HP,
   parameter logic [NUM_ATK*HP_W-1:0] ATK_DMG = DEF_ATK_DMG,
   parameter int ENEMY_W = DEF_ENEMY_W,
   parameter int ENEMY_H = DEF_ENEMY_H,
   parameter int SPAWN_FRAMES = DEF_SPAWN_FRAMES,
   parameter int INV_FRAMES = DEF_INV_FRAMES,
   parameter int ENEMY_DMG = DEF_ENEMY_DMG,
   parameter int DMG_W = DEF_DMG_W,
   parameter int SCORE_W = DEF_SCORE_W
) (
   input  logic                       Clk,
   input  logic                       Reset,
   input  logic                       Frame_Tick,
   input  logic [COORD_W-1:0]         Enemy_X,
   input  logic [COORD_W-1:0]         Enemy_Y,
   input  logic [NUM_ATK-1:0]         Atk_On,
   input  logic [NUM_ATK*COORD_W-1:0] Atk_X,
   input  logic [NUM_ATK*COORD_W-1:0] Atk_Y,
   input  logic [NUM_ATK*COORD_W-1:0] Atk_W,
   input  logic [NUM_ATK*COORD_W-1:0] Atk_H,
   input  logic [9:0]                 Respawn_Unit,
   input  logic                       Enemy_Attack_Valid,
   input  logic                       Godmode_On,
   output logic                       Enemy_Alive,
   output logic [HP_W-1:0]            Enemy_HP,
   output logic [1:0]                 Enemy_State,
   output logic [NUM_ATK-1:0]         Hit,
   output logic                       Killed,
   output logic [SCORE_W-1:0]         Enemy_Score,
   output logic [DMG_W-1:0]           Total_Damage,
   output logic [DMG_W-1:0]           Total_Damage_God
);
   enemy_state_e state, state_n;
   logic [15:0] rcnt, rcnt_n, fcnt, fcnt_n, target, dmg;
   logic [HP_W-1:0] hp_n;
   logic [NUM_ATK-1:0] ovl, hit_n;
   logic killed_n;
   logic [SCORE_W-1:0] score_n;
   logic [DMG_W-1:0] td_n, tg_n;
   assign target = 16'(Respawn_Unit) * 16'(ENEMY_ID + 1);
   for (genvar i = 0; i < NUM_ATK; i++) begin : g_hit
      aabb_hit #(.COORD_W(COORD_W), .ENEMY_W(ENEMY_W), .ENEMY_H(ENEMY_H)) u_hit (
         .on (Atk_On[i]),
         .ex (Enemy_X),
         .ey (Enemy_Y),
         .ax (Atk_X[i*COORD_W +: COORD_W]),
         .ay (Atk_Y[i*COORD_W +: COORD_W]),
         .aw (Atk_W[i*COORD_W +: COORD_W]),
         .ah (Atk_H[i*COORD_W +: COORD_W]),
         .hit(ovl[i])
      );
   end
   always_comb begin
      dmg = '0;
      for (int k = 0; k < NUM_ATK; k++) dmg = dmg + (ovl[k] ? 16'(ATK_DMG[k*HP_W +: HP_W]) : 16'd0);
   end
   always_comb begin
      state_n = state;
      rcnt_n = rcnt;
      fcnt_n = fcnt;
      hp_n = Enemy_HP;
      hit_n = '0;
      killed_n = 1'b0;
      score_n = Enemy_Score;
      td_n = Total_Damage;
      tg_n = Total_Damage_God;
      if (Frame_Tick) begin
         case (state)
            DEAD: begin
               if (rcnt == target) begin
                  state_n = SPAWN;
                  hp_n = HP_W'(FULL_HP);
                  rcnt_n = '0;
                  fcnt_n = '0;
               end else rcnt_n = rcnt + 16'd1;
            end
            SPAWN: begin
               if (fcnt == 16'(SPAWN_FRAMES - 1)) state_n = ALIVE;
               else fcnt_n = fcnt + 16'd1;
            end
            ALIVE: begin
               if (dmg >= 16'(Enemy_HP)) begin
                  state_n = DEAD;
                  hp_n = '0;
                  hit_n = ovl;
                  killed_n = 1'b1;
                  rcnt_n = '0;
                  score_n = SCORE_W'(sat_add(32'(Enemy_Score), 32'd1, SCORE_W));
               end else if (dmg != 16'd0) begin
                  state_n = HURT;
                  hp_n = Enemy_HP - HP_W'(dmg);
                  hit_n = ovl;
                  fcnt_n = '0;
               end
            end
            HURT: begin
               if (fcnt == 16'(INV_FRAMES - 1)) state_n = ALIVE;
               else fcnt_n = fcnt + 16'd1;
            end
            default: state_n = DEAD;
         endcase
         if (Enemy_Attack_Valid && (state == ALIVE || state == HURT)) begin
            if (Godmode_On) tg_n = DMG_W'(sat_add(32'(Total_Damage_God), 32'(ENEMY_DMG), DMG_W));
            else td_n = DMG_W'(sat_add(32'(Total_Damage), 32'(ENEMY_DMG), DMG_W));
         end
      end
   end
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state <= DEAD;
         rcnt <= '0;
         fcnt <= '0;
         Enemy_HP <= '0;
         Hit <= '0;
         Killed <= 1'b0;
         Enemy_Score <= '0;
         Total_Damage <= '0;
         Total_Damage_God <= '0;
      end else begin
         state <= state_n;
         rcnt <= rcnt_n;
         fcnt <= fcnt_n;
         Enemy_HP <= hp_n;
         Hit <= hit_n;
         Killed <= killed_n;
         Enemy_Score <= score_n;
         Total_Damage <= td_n;
         Total_Damage_God <= tg_n;
      end
   end
   assign Enemy_State = state;
   assign Enemy_Alive = state != DEAD;
endmodule

// File: tb/tb_enemy_health_fsm.sv
// tb_enemy_health_fsm: directed and randomized checks of enemy_health_fsm against a rule-level model
module tb_enemy_health_fsm;
   localparam int ID = 1;
   localparam int ST_DEAD = 0, ST_SPAWN = 1, ST_ALIVE = 2, ST_HURT = 3;
   logic Clk = 1'b0;
   logic Reset = 1'b1;
   logic Frame_Tick = 1'b0;
   logic [8:0] Enemy_X = 9'd100, Enemy_Y = 9'd100;
   logic [1:0] Atk_On = '0;
   logic [17:0] Atk_X = '0, Atk_Y = '0, Atk_W = '0, Atk_H = '0;
   logic [9:0] Respawn_Unit = 10'd3;
   logic Enemy_Attack_Valid = 1'b0, Godmode_On = 1'b0;
   logic Enemy_Alive, Killed;
   logic [6:0] Enemy_HP;
   logic [1:0] Enemy_State, Hit;
   logic [9:0] Enemy_Score, Total_Damage, Total_Damage_God;
   int n_cmp = 0, n_bad = 0;
   int m_st, m_hp, m_rem, m_score, m_td, m_tg, m_hit, m_kill;

   enemy_health_fsm #(.ENEMY_ID(ID)) dut (
      .Clk(Clk), .Reset(Reset), .Frame_Tick(Frame_Tick),
      .Enemy_X(Enemy_X), .Enemy_Y(Enemy_Y), .Atk_On(Atk_On),
      .Atk_X(Atk_X), .Atk_Y(Atk_Y), .Atk_W(Atk_W), .Atk_H(Atk_H),
      .Respawn_Unit(Respawn_Unit), .Enemy_Attack_Valid(Enemy_Attack_Valid), .Godmode_On(Godmode_On),
      .Enemy_Alive(Enemy_Alive), .Enemy_HP(Enemy_HP), .Enemy_State(Enemy_State), .Hit(Hit),
      .Killed(Killed), .Enemy_Score(Enemy_Score), .Total_Damage(Total_Damage),
      .Total_Damage_God(Total_Damage_God)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic bit overlaps(input int c);
      int ax, ay, aw, ah;
      ax = int'(Atk_X[c*9 +: 9]);
      ay = int'(Atk_Y[c*9 +: 9]);
      aw = int'(Atk_W[c*9 +: 9]);
      ah = int'(Atk_H[c*9 +: 9]);
      return Atk_On[c] && (int'(Enemy_X) + 26 >= ax) && (int'(Enemy_X) <= ax + aw)
             && (int'(Enemy_Y) + 26 >= ay) && (int'(Enemy_Y) <= ay + ah);
   endfunction

   task automatic model_reset();
      m_st = ST_DEAD; m_hp = 0; m_score = 0; m_td = 0; m_tg = 0; m_hit = 0; m_kill = 0;
      m_rem = int'(Respawn_Unit) * (ID + 1);
   endtask

   // timers here count down the ticks remaining before the next phase
   task automatic model_tick();
      int d, ov;
      m_hit = 0;
      m_kill = 0;
      ov = (overlaps(0) ? 1 : 0) + (overlaps(1) ? 2 : 0);
      d = (overlaps(0) ? 10 : 0) + (overlaps(1) ? 25 : 0);
      if (Enemy_Attack_Valid && (m_st == ST_ALIVE || m_st == ST_HURT)) begin
         if (Godmode_On) m_tg = (m_tg + 10 > 1023) ? 1023 : m_tg + 10;
         else m_td = (m_td + 10 > 1023) ? 1023 : m_td + 10;
      end
      if (m_st == ST_DEAD) begin
         if (m_rem == 0) begin m_st = ST_SPAWN; m_hp = 100; m_rem = 29; end
         else m_rem--;
      end else if (m_st == ST_SPAWN) begin
         if (m_rem == 0) m_st = ST_ALIVE;
         else m_rem--;
      end else if (m_st == ST_ALIVE) begin
         if (d >= m_hp) begin
            m_st = ST_DEAD; m_hp = 0; m_hit = ov; m_kill = 1;
            m_score = (m_score == 1023) ? 1023 : m_score + 1;
            m_rem = int'(Respawn_Unit) * (ID + 1);
         end else if (d > 0) begin
            m_st = ST_HURT; m_hp -= d; m_hit = ov; m_rem = 7;
         end
      end else begin
         if (m_rem == 0) m_st = ST_ALIVE;
         else m_rem--;
      end
   endtask

   task automatic check_all(input string c);
      chk({c, ".state"}, 32'(Enemy_State), m_st);
      chk({c, ".hp"}, 32'(Enemy_HP), m_hp);
      chk({c, ".alive"}, 32'(Enemy_Alive), 32'(m_st != ST_DEAD));
      chk({c, ".hit"}, 32'(Hit), m_hit);
      chk({c, ".killed"}, 32'(Killed), m_kill);
      chk({c, ".score"}, 32'(Enemy_Score), m_score);
      chk({c, ".dmg"}, 32'(Total_Damage), m_td);
      chk({c, ".dmg_god"}, 32'(Total_Damage_God), m_tg);
   endtask

   task automatic step(input bit tk, input string c);
      Frame_Tick = tk;
      if (Reset) model_reset();
      else if (tk) model_tick();
      else begin m_hit = 0; m_kill = 0; end
      @(posedge Clk);
      #1;
      Frame_Tick = 1'b0;
      check_all(c);
   endtask

   task automatic set_atk(input int c, input bit on, input int x, input int y, input int w, input int h);
      Atk_On[c] = on;
      Atk_X[c*9 +: 9] = 9'(x);
      Atk_Y[c*9 +: 9] = 9'(y);
      Atk_W[c*9 +: 9] = 9'(w);
      Atk_H[c*9 +: 9] = 9'(h);
   endtask

   initial begin
      model_reset();
      step(0, "reset");
      step(1, "reset_tick");
      Reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step(1, "dead_wait");
         step(0, "dead_idle");
      end
      chk("still_dead", 32'(Enemy_State), ST_DEAD);
      step(1, "spawn");
      chk("spawn_hp", 32'(Enemy_HP), 100);
      for (int i = 0; i < 29; i++) step(1, "spawn_prot");
      chk("spawn_hold", 32'(Enemy_State), ST_SPAWN);
      step(1, "to_alive");
      chk("alive_now", 32'(Enemy_State), ST_ALIVE);
      Enemy_Attack_Valid = 1'b1;
      for (int i = 0; i < 3; i++) step(1, "pdmg");
      Godmode_On = 1'b1;
      for (int i = 0; i < 2; i++) step(1, "pdmg_god");
      Enemy_Attack_Valid = 1'b0;
      Godmode_On = 1'b0;
      chk("pdmg_total", 32'(Total_Damage), 30);
      chk("pdmg_god_total", 32'(Total_Damage_God), 20);
      set_atk(0, 1, 110, 110, 10, 10);
      step(1, "hit0");
      chk("hit0_hp", 32'(Enemy_HP), 90);
      chk("hit0_bits", 32'(Hit), 1);
      step(0, "hit0_pulse_end");
      for (int i = 0; i < 7; i++) step(1, "inv_frames");
      chk("inv_hp", 32'(Enemy_HP), 90);
      set_atk(0, 0, 110, 110, 10, 10);
      step(1, "inv_exit");
      set_atk(0, 1, 126, 100, 10, 10);
      step(1, "edge_touch");
      chk("edge_touch_hit", 32'(Hit), 1);
      set_atk(0, 0, 126, 100, 10, 10);
      for (int i = 0; i < 8; i++) step(1, "edge_inv");
      set_atk(0, 1, 127, 100, 10, 10);
      step(1, "edge_gap");
      chk("edge_gap_hit", 32'(Hit), 0);
      set_atk(0, 0, 127, 100, 10, 10);
      for (int i = 0; i < 10 && m_hp > 30; i++) begin
         set_atk(0, 1, 110, 110, 10, 10);
         step(1, "wear_down");
         set_atk(0, 0, 110, 110, 10, 10);
         for (int j = 0; j < 8; j++) step(1, "wear_inv");
      end
      chk("hp_at_30", 32'(Enemy_HP), 30);
      set_atk(0, 1, 110, 110, 10, 10);
      set_atk(1, 1, 90, 90, 20, 20);
      step(1, "kill");
      chk("kill_pulse", 32'(Killed), 1);
      chk("kill_hit", 32'(Hit), 3);
      chk("kill_score", 32'(Enemy_Score), 1);
      set_atk(0, 0, 0, 0, 0, 0);
      set_atk(1, 0, 0, 0, 0, 0);
      step(0, "kill_pulse_end");
      Enemy_Attack_Valid = 1'b1;
      for (int i = 0; i < 3; i++) step(1, "dead_no_pdmg");
      chk("dead_pdmg_hold", 32'(Total_Damage), 30);
      for (int i = 0; i < 200 && m_st != ST_ALIVE; i++) step(1, "respawn_run");
      chk("respawned", 32'(Enemy_State), ST_ALIVE);
      for (int i = 0; i < 105; i++) step(1, "pdmg_sat");
      chk("pdmg_saturated", 32'(Total_Damage), 1023);
      Enemy_Attack_Valid = 1'b0;
      set_atk(0, 1, 110, 110, 10, 10);
      step(1, "hurt_again");
      set_atk(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(1, "mid_hurt");
      Reset = 1'b1;
      step(1, "reset_mid_hurt");
      chk("rst_state", 32'(Enemy_State), ST_DEAD);
      chk("rst_score", 32'(Enemy_Score), 0);
      Respawn_Unit = 10'd0;
      step(0, "rst_ru0");
      Reset = 1'b0;
      step(1, "ru0_spawn");
      chk("ru0_state", 32'(Enemy_State), ST_SPAWN);
      Reset = 1'b1;
      Respawn_Unit = 10'($urandom_range(0, 2));
      step(0, "rand_reset");
      Reset = 1'b0;
      for (int i = 0; i < 700; i++) begin
         int ex, ey;
         if (i % 60 == 0) begin
            Enemy_X = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(480, 511)) : 9'($urandom_range(60, 200));
            Enemy_Y = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(480, 511)) : 9'($urandom_range(60, 200));
         end
         ex = int'(Enemy_X);
         ey = int'(Enemy_Y);
         for (int c = 0; c < 2; c++) begin
            int ax, ay;
            ax = ex + int'($urandom_range(0, 90)) - 45;
            ay = ey + int'($urandom_range(0, 90)) - 45;
            ax = (ax < 0) ? 0 : (ax > 511) ? 511 : ax;
            ay = (ay < 0) ? 0 : (ay > 511) ? 511 : ay;
            set_atk(c, 1'($urandom_range(0, 1)), ax, ay, int'($urandom_range(0, 30)), int'($urandom_range(0, 30)));
         end
         Enemy_Attack_Valid = 1'($urandom_range(0, 1));
         Godmode_On = 1'($urandom_range(0, 1));
         step(($urandom_range(0, 9) < 7), "random");
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/enemy_health_fsm.md
Name: enemy_health_fsm

Overview:
- Per-enemy health, respawn and scoring controller. Generalises the single-enemy game-logic block to:
  - NUM_ATK player attack channels;
  - caller-supplied hitboxes;
  - an explicit life-cycle state machine with spawn protection and post-hit invulnerability frames;
  - saturating arithmetic throughout.
- One instance per enemy, indexed by ENEMY_ID. It sits between the player/attack sprite logic and the score/HUD logic.

Parameters:
ENEMY_ID, 0, enemy index; respawn delay = Respawn_Unit * (ENEMY_ID+1) frames
NUM_ATK, 2, number of player attack channels
COORD_W, 9, coordinate width
HP_W, 7, health width
FULL_HP, 100, health on spawn
ATK_DMG, {7'd25,7'd10}, packed NUM_ATK*HP_W damage per channel; channel 0 is in the LSBs
ENEMY_W, 26, enemy hitbox width
ENEMY_H, 26, enemy hitbox height
SPAWN_FRAMES, 30, frames of invulnerability after spawn
INV_FRAMES, 8, frames of invulnerability after a hit
ENEMY_DMG, 10, damage dealt to player per valid enemy attack
DMG_W, 10, player-damage accumulator width
SCORE_W, 10, score width

Ports:
Clk  in  1  clock
Reset  in  1  synchronous, active-high
Frame_Tick  in  1  one-cycle game-frame rising-edge pulse
Enemy_X, Enemy_Y  in  COORD_W  enemy top-left
Atk_On  in  NUM_ATK  per-channel attack active
Atk_X, Atk_Y  in  NUM_ATK*COORD_W  per-channel attack box top-left
Atk_W, Atk_H  in  NUM_ATK*COORD_W  per-channel attack box size, already rotated by player direction
Respawn_Unit  in  10  frames per respawn unit
Enemy_Attack_Valid  in  1  enemy attack landed on player
Godmode_On  in  1  route player damage to the god accumulator
Enemy_Alive  out  1  state is SPAWN, ALIVE or HURT
Enemy_HP  out  HP_W  current health
Enemy_State  out  2  encoded state
Hit  out  NUM_ATK  per-channel damage-applied pulse, one cycle
Killed  out  1  one-cycle pulse on the transition to DEAD
Enemy_Score  out  SCORE_W  kill count
Total_Damage, Total_Damage_God  out  DMG_W  damage dealt to the player

Behaviour:
- Reset values:
  - state = DEAD, HP = 0, respawn counter = 0, frame counter = 0;
  - Score = 0, both damage accumulators = 0;
  - Hit = 0, Killed = 0.
- All state changes occur only in cycles where Frame_Tick = 1. Outputs are registered, so Hit and Killed assert the cycle after the tick.
- Overlap on channel i: Atk_On[i] & (Enemy_X+ENEMY_W >= AX) & (Enemy_X <= AX+AW) & (Enemy_Y+ENEMY_H >= AY) & (Enemy_Y <= AY+AH).
  - Sums are computed at COORD_W+1 bits, so there is no wrap-around.
  - Edges touching counts as a hit (inclusive).
- DEAD:
  - The respawn counter increments each tick.
  - When counter == Respawn_Unit*(ENEMY_ID+1), computed at 16 bits: HP = FULL_HP, counter cleared, go to SPAWN.
  - Respawn_Unit = 0 respawns on the first tick.
- SPAWN:
  - Hits are ignored.
  - The frame counter counts to SPAWN_FRAMES-1, then the block goes to ALIVE.
- ALIVE, total damage D = sum of ATK_DMG[i] over all overlapping channels in the same tick:
  - D >= HP: HP = 0, go to DEAD, Killed pulses, Score += 1 (saturating at all-ones). Hit bits still report the overlapping channels.
  - 0 < D < HP: HP -= D, Hit bits set, go to HURT, frame counter cleared.
  - D = 0: no change.
- HURT:
  - Hits are ignored and Hit stays 0.
  - After INV_FRAMES ticks, go to ALIVE.
- Player damage:
  - Applies on Enemy_Attack_Valid & Frame_Tick & state ∈ {ALIVE, HURT}.
  - Adds ENEMY_DMG to Total_Damage_God if Godmode_On, otherwise to Total_Damage. The other accumulator holds.
  - Both accumulators saturate at 2^DMG_W-1.
- Reset asserted in any state, mid-countdown included, returns everything to reset values on the next edge.

Decomposition:
- Package enemy_pkg holds:
  - the state enum: DEAD=2'd0, SPAWN=2'd1, ALIVE=2'd2, HURT=2'd3;
  - the default damage/size constants;
  - a saturating-add function.
- Sub-module aabb_hit: combinational overlap test, instantiated NUM_ATK times via generate.

Test Plan:
1. Reset, ENEMY_ID=1, Respawn_Unit=3 -> DEAD for 6 ticks; on the 7th tick HP=100 and state=SPAWN; ALIVE after 30 more ticks.
2. ALIVE, HP=100, channel 0 overlaps (damage 10) -> HP=90, Hit=2'b01, state=HURT; a repeat overlap within 8 ticks leaves HP=90.
3. ALIVE, HP=30, channels 0 and 1 overlap in the same tick (10+25) -> HP=0, Killed pulse, Score 0->1, state=DEAD, Hit=2'b11.
4. Boxes touching exactly at an edge (Enemy_X+26 == Atk_X) -> counts as a hit; Enemy_X+26 == Atk_X-1 -> no hit.
5. Enemy_Attack_Valid for 3 ticks with Godmode_On=0, then 2 ticks with Godmode_On=1 -> Total_Damage=30, Total_Damage_God=20; while DEAD no accumulation; Total_Damage preset near 1023 saturates at 1023.
6. Reset asserted mid-HURT -> next cycle state=DEAD, HP=0, Score=0, all outputs at reset values.
